// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage responder: default widths,
// wait-counter width and the access FSM state encoding.
package mem_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_wait_cnt.sv
// Loadable down-counter that times SRAM wait states; zero marks the
// final cycle of an access.
module mem_wait_cnt
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/mem_responder.sv
// Memory-stage responder: single-cycle IP peripheral writes and
// multi-cycle SRAM accesses that stall the pipeline until data is ready.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address_in,
  input  logic              datarw_in,
  input  logic              dataena_in,
  input  logic              IP_write_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              stall_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic              rdata_valid_out,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [7:0]        ip_addr_out,
  output logic [DATA_W-1:0] ip_wdata_out,
  output logic              ip_we_out,
  output logic              err_out
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = WAIT_CYCLES[CNT_W-1:0];

  mem_state_e state_reg;
  mem_state_e state_next;

  logic idle;
  logic accept_sram;
  logic ip_write;
  logic ip_illegal;
  logic in_access;
  logic cnt_zero;
  logic last_access;

  assign idle        = (state_reg == IDLE);
  assign in_access   = (state_reg == ACCESS);
  assign accept_sram = idle & dataena_in & ~IP_write_in;
  assign ip_write    = idle & dataena_in & IP_write_in & datarw_in;
  assign ip_illegal  = idle & dataena_in & IP_write_in & ~datarw_in;
  assign last_access = in_access & cnt_zero;

  mem_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_sram),
    .dec      (in_access),
    .load_val (WAIT_LOAD),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Stall is combinational so the pipeline freezes in the acceptance cycle;
  // it is gated by rst so an abort drops it immediately.
  always_comb begin
    state_next = state_reg;
    stall_out  = 1'b0;
    case (state_reg)
      IDLE:    if (accept_sram) state_next = ACCESS;
      ACCESS:  if (cnt_zero) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    stall_out = ~rst & (accept_sram | in_access);
  end

  // SRAM port: captured at acceptance, held constant through ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else if (accept_sram) begin
      sram_ce    <= 1'b1;
      sram_we    <= datarw_in;
      sram_addr  <= address_in;
      sram_wdata <= wdata_in;
    end else if (last_access) begin
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_out       <= '0;
      rdata_valid_out <= 1'b0;
    end else begin
      rdata_valid_out <= last_access & ~sram_we;
      if (last_access && !sram_we) begin
        rdata_out <= sram_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ip_we_out    <= 1'b0;
      ip_addr_out  <= '0;
      ip_wdata_out <= '0;
      err_out      <= 1'b0;
    end else begin
      ip_we_out <= ip_write;
      if (ip_write) begin
        ip_addr_out  <= address_in[7:0];
        ip_wdata_out <= wdata_in;
      end
      if (ip_illegal) begin
        err_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random
// transactions compared against a transaction-level reference model.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] address_in = '0;
  logic        datarw_in = 1'b0;
  logic        dataena_in = 1'b0;
  logic        en0 = 1'b0;
  logic        ip_write_in = 1'b0;
  logic [31:0] wdata_in = '0;
  logic [31:0] sram_rdata = '0;

  logic        stall_out, rdata_valid_out, sram_ce, sram_we, ip_we_out, err_out;
  logic [31:0] rdata_out, sram_wdata, ip_wdata_out;
  logic [19:0] sram_addr;
  logic [7:0]  ip_addr_out;

  logic        stall_0, rvalid_0, ce_0, we_0, ipwe_0, err_0;
  logic [31:0] rdata_0, swd_0, ipwd_0;
  logic [19:0] saddr_0;
  logic [7:0]  ipaddr_0;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_rd [2];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .address_in(address_in), .datarw_in(datarw_in),
    .dataena_in(dataena_in), .IP_write_in(ip_write_in), .wdata_in(wdata_in),
    .stall_out(stall_out), .rdata_out(rdata_out), .rdata_valid_out(rdata_valid_out),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ce(sram_ce), .sram_we(sram_we), .ip_addr_out(ip_addr_out),
    .ip_wdata_out(ip_wdata_out), .ip_we_out(ip_we_out), .err_out(err_out)
  );

  mem_responder #(.ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .address_in(address_in), .datarw_in(datarw_in),
    .dataena_in(en0), .IP_write_in(ip_write_in), .wdata_in(wdata_in),
    .stall_out(stall_0), .rdata_out(rdata_0), .rdata_valid_out(rvalid_0),
    .sram_addr(saddr_0), .sram_wdata(swd_0), .sram_rdata(sram_rdata),
    .sram_ce(ce_0), .sram_we(we_0), .ip_addr_out(ipaddr_0),
    .ip_wdata_out(ipwd_0), .ip_we_out(ipwe_0), .err_out(err_0)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One SRAM transaction; the request is held while stall is seen high.
  task automatic txn(input bit inst, input bit rw, input logic [19:0] a,
                     input logic [31:0] wd, input bit use_fixed, input logic [31:0] fixed);
    int w, stall_n, ce_n, ok_n, v_n, first_low;
    logic prev_stall, s_stall, s_ce, s_we, s_valid;
    logic [19:0] s_addr;
    logic [31:0] s_wd, s_rd, cur, exp_rd, v_data;
    w = inst ? 0 : 2;
    stall_n = 0; ce_n = 0; ok_n = 0; v_n = 0; first_low = -1;
    prev_stall = 1'b1; exp_rd = last_rd[inst]; v_data = '0;
    address_in = a; datarw_in = rw; wdata_in = wd; ip_write_in = 1'b0;
    for (int k = 0; k < w + 6; k++) begin
      @(negedge clk);
      cur = use_fixed ? fixed : $urandom;
      sram_rdata = cur;
      if (k == w + 1 && !rw) exp_rd = cur;
      if (inst) en0 = prev_stall; else dataena_in = prev_stall;
      #1;
      s_stall = inst ? stall_0  : stall_out;
      s_ce    = inst ? ce_0     : sram_ce;
      s_we    = inst ? we_0     : sram_we;
      s_valid = inst ? rvalid_0 : rdata_valid_out;
      s_addr  = inst ? saddr_0  : sram_addr;
      s_wd    = inst ? swd_0    : sram_wdata;
      s_rd    = inst ? rdata_0  : rdata_out;
      if (k == 0) chk("accept_stall", {63'd0, s_stall}, 64'd1);
      prev_stall = s_stall;
      if (s_stall) stall_n++;
      else if (first_low < 0) first_low = k;
      if (s_ce) begin
        ce_n++;
        if (s_we === rw && s_addr === a && (!rw || s_wd === wd)) ok_n++;
      end
      if (s_valid) begin
        v_n++;
        v_data = s_rd;
      end
    end
    en0 = 1'b0; dataena_in = 1'b0;
    chk("stall_cycles", 64'(stall_n), 64'(w + 2));
    chk("stall_contig", 64'(first_low), 64'(w + 2));
    chk("ce_cycles", 64'(ce_n), 64'(w + 1));
    chk("ce_fields", 64'(ok_n), 64'(w + 1));
    chk("valid_pulses", 64'(v_n), rw ? 64'd0 : 64'd1);
    if (!rw) chk("valid_data", {32'd0, v_data}, {32'd0, exp_rd});
    chk("rdata_hold", {32'd0, inst ? rdata_0 : rdata_out}, {32'd0, exp_rd});
    last_rd[inst] = exp_rd;
    $display("txn inst=W%0d %s addr=%05h wdata=%08h rdata_exp=%08h stall=%0d ce=%0d",
             w, rw ? "WR" : "RD", a, wd, exp_rd, stall_n, ce_n);
  endtask

  // Back-to-back IP writes; each must appear as a strobe the following cycle.
  task automatic ip_burst(input int n, input logic [19:0] a0, input logic [19:0] step);
    logic [19:0] ea [4];
    logic [31:0] ed [4];
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i < n) begin
        ea[i] = a0 + 20'(i) * step;
        ed[i] = $urandom;
        address_in = ea[i]; wdata_in = ed[i];
        datarw_in = 1'b1; ip_write_in = 1'b1; dataena_in = 1'b1;
      end else begin
        dataena_in = 1'b0; ip_write_in = 1'b0;
      end
      #1;
      chk("ip_no_stall", {63'd0, stall_out}, 64'd0);
      chk("ip_no_ce", {63'd0, sram_ce}, 64'd0);
      if (i > 0) begin
        chk("ip_we", {63'd0, ip_we_out}, 64'd1);
        chk("ip_addr", {56'd0, ip_addr_out}, {56'd0, ea[i-1][7:0]});
        chk("ip_wdata", {32'd0, ip_wdata_out}, {32'd0, ed[i-1]});
        $display("ipwr addr=%02h wdata=%08h", ea[i-1][7:0], ed[i-1]);
      end
    end
    @(negedge clk); #1;
    chk("ip_we_drop", {63'd0, ip_we_out}, 64'd0);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      chk("idle_quiet", {60'd0, stall_out, sram_ce, ip_we_out, rdata_valid_out}, 64'd0);
      chk("idle_hold", {32'd0, rdata_out}, {32'd0, last_rd[0]});
    end
    $display("idle cycles=%0d rdata_hold=%08h", n, last_rd[0]);
  endtask

  initial begin
    int kind, vcount;
    last_rd[0] = '0; last_rd[1] = '0;
    #1 rst = 1'b1;
    dataena_in = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_quiet", {58'd0, stall_out, sram_ce, sram_we, rdata_valid_out, ip_we_out, err_out}, 64'd0);
    chk("rst_vals", {32'd0, rdata_out | sram_wdata | ip_wdata_out}, 64'd0);
    chk("rst_addr", {36'd0, sram_addr, ip_addr_out}, 64'd0);
    chk("rst_dut0", {58'd0, stall_0, ce_0, rvalid_0, ipwe_0, err_0, we_0}, 64'd0);
    $display("reset checked");
    @(negedge clk);
    dataena_in = 1'b0;
    rst = 1'b0;

    txn(1'b0, 1'b0, 20'h12345, 32'h0, 1'b1, 32'hDEADBEEF);
    txn(1'b0, 1'b1, 20'h00010, 32'hA5A5A5A5, 1'b0, 32'h0);
    ip_burst(3, 20'h00004, 20'h00004);

    @(negedge clk);
    address_in = 20'h00020; datarw_in = 1'b0; ip_write_in = 1'b1; dataena_in = 1'b1;
    #1;
    chk("err_before", {63'd0, err_out}, 64'd0);
    chk("err_no_stall", {63'd0, stall_out}, 64'd0);
    @(negedge clk);
    dataena_in = 1'b0; ip_write_in = 1'b0;
    #1;
    chk("err_set", {63'd0, err_out}, 64'd1);
    chk("err_no_access", {62'd0, ip_we_out, sram_ce}, 64'd0);
    $display("illegal ip read err=%0b", err_out);

    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: txn(1'b0, 1'b0, 20'($urandom), 32'($urandom), 1'b0, 32'h0);
        1: txn(1'b0, 1'b1, 20'($urandom), 32'($urandom), 1'b0, 32'h0);
        2: ip_burst($urandom_range(1, 3), 20'($urandom), 20'($urandom_range(1, 64)));
        default: idle_check($urandom_range(1, 4));
      endcase
    end
    chk("err_sticky", {63'd0, err_out}, 64'd1);

    // Abort a read in its second ACCESS cycle.
    address_in = 20'h0ABCD; datarw_in = 1'b0; ip_write_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      dataena_in = 1'b1;
      sram_rdata = $urandom;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ce", {63'd0, sram_ce}, 64'd0);
    chk("abort_stall", {63'd0, stall_out}, 64'd0);
    chk("abort_rdata", {32'd0, rdata_out}, 64'd0);
    chk("abort_err", {63'd0, err_out}, 64'd0);
    last_rd[0] = '0; last_rd[1] = '0;
    @(negedge clk);
    rst = 1'b0; dataena_in = 1'b0;
    vcount = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      if (rdata_valid_out) vcount++;
    end
    chk("abort_no_valid", 64'(vcount), 64'd0);
    $display("abort mid-access checked");
    txn(1'b0, 1'b0, 20'h0ABCD, 32'h0, 1'b0, 32'h0);

    txn(1'b1, 1'b0, 20'h00100, 32'h0, 1'b0, 32'h0);
    txn(1'b1, 1'b1, 20'h00200, 32'h12345678, 1'b0, 32'h0);
    for (int t = 0; t < 4; t++) begin
      txn(1'b1, 1'($urandom_range(0, 1)), 20'($urandom), 32'($urandom), 1'b0, 32'h0);
    end
    chk("dut0_quiet", {32'd0, ipwd_0 | {23'd0, ipaddr_0, ipwe_0}}, 64'd0);
    chk("dut0_err", {63'd0, err_0}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, memory-stage address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, SRAM wait states, legal range 0..15.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 address_in  input  ADDR_W  request address from EX/MEM register.
REQ-007 datarw_in  input  1  1 = write, 0 = read.
REQ-008 dataena_in  input  1  request valid.
REQ-009 IP_write_in  input  1  write targets IP peripheral port, not SRAM.
REQ-010 wdata_in  input  DATA_W  write data.
REQ-011 stall_out  output  1  hold pipeline; request inputs stable while high.
REQ-012 rdata_out  output  DATA_W  read data, held until next read completes.
REQ-013 rdata_valid_out  output  1  one-cycle pulse, rdata_out updated.
REQ-014 sram_addr  output  ADDR_W; sram_wdata  output  DATA_W; sram_rdata  input  DATA_W; sram_ce  output  1; sram_we  output  1.
REQ-015 ip_addr_out  output  8; ip_wdata_out  output  DATA_W; ip_we_out  output  1 (one-cycle strobe).
REQ-016 err_out  output  1  sticky flag, illegal request seen.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-018 IDLE, dataena_in=1, IP_write_in=1, datarw_in=1: next cycle ip_we_out=1, ip_addr_out=address_in[7:0], ip_wdata_out=wdata_in; no stall; FSM stays IDLE; back-to-back IP writes every cycle supported.
REQ-019 IDLE, dataena_in=1, IP_write_in=1, datarw_in=0: illegal; err_out set to 1 next edge, no IP or SRAM access.
REQ-020 IDLE, dataena_in=1, IP_write_in=0: SRAM request accepted; address, datarw, wdata captured; FSM -> ACCESS; stall_out asserted combinationally in the acceptance cycle.
REQ-021 ACCESS SHALL last exactly WAIT_CYCLES+1 cycles: sram_ce=1, sram_we=captured datarw, sram_addr/sram_wdata=captured values, all registered and constant through the state.
REQ-022 Read: sram_rdata SHALL be sampled into rdata_out on the edge ending the last ACCESS cycle.
REQ-023 DONE SHALL last one cycle: sram_ce=0, stall_out=0, rdata_valid_out=1 for reads only; FSM -> IDLE; new request not accepted in DONE.
REQ-024 stall_out SHALL be high for exactly WAIT_CYCLES+2 cycles per SRAM access (acceptance + ACCESS).
REQ-025 stall_out=1 in all ACCESS cycles; dataena_in changes during ACCESS ignored.
REQ-026 Wait counter width 4 bits, loads WAIT_CYCLES on entry to ACCESS, decrements to 0; exit ACCESS when counter = 0.
REQ-027 dataena_in=0 in IDLE: all strobes low, outputs hold.
REQ-028 Address SHALL be full ADDR_W map; no range check, wrap not applicable.

Reset
REQ-029 rst=1 SHALL force FSM IDLE, counter 0, stall_out=0, sram_ce=0, sram_we=0, sram_addr=0, sram_wdata=0, rdata_out=0, rdata_valid_out=0, ip_we_out=0, ip_addr_out=0, ip_wdata_out=0, err_out=0.
REQ-030 Reset mid-ACCESS SHALL abort immediately: sram_ce low, no rdata_valid_out pulse, rdata_out cleared.
REQ-031 err_out SHALL clear only on rst.

Structure
REQ-032 Shared package mem_pkg SHALL hold ADDR_W, DATA_W defaults and the FSM state enumeration.
REQ-033 One sub-module mem_wait_cnt (4-bit loadable down-counter with zero flag) SHALL implement REQ-026; all else in mem_responder.

Verification
REQ-034 Read, WAIT_CYCLES=2, address 0x12345, sram_rdata=0xDEADBEEF -> stall 4 cycles, sram_ce 3 cycles, rdata_out=0xDEADBEEF with rdata_valid_out pulse in DONE.
REQ-035 Write, address 0x00010, wdata 0xA5A5A5A5 -> sram_we=1, sram_ce 3 cycles, no rdata_valid_out.
REQ-036 Three consecutive IP writes, addresses 0x00004/0x00008/0x0000C -> three ip_we_out pulses, ip_addr_out 0x04/0x08/0x0C, stall_out never high.
REQ-037 IP_write_in=1 with datarw_in=0 -> err_out=1 and stays high; no ip_we_out, no sram_ce.
REQ-038 rst asserted in second ACCESS cycle of a read -> sram_ce=0 and stall_out=0 same cycle, no rdata_valid_out, next read completes normally.
REQ-039 WAIT_CYCLES=0 read -> stall 2 cycles, sram_ce 1 cycle, correct data.
